id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RISC-V core. It captures decoded operands and control from the decode stage each cycle. It produces the rs1_ex/rs2_ex/rd_ex indices consumed by the EX-stage operand-forwarding units. It raises fetch/decode stalls and inserts EX bubbles on load-use hazards and taken branches/jumps resolved in EX.

## Interface
Parameters:
- XLEN, 32, datapath width of rd1/rd2/imm/pc fields
- CNT_W, 16, width of the saturating load-use stall counter

Ports (clk, reset_n: one clock, reset is synchronous and active-low):
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- valid_d  in  1  decode stage holds a real instruction
- rs1_d, rs2_d, rd_d  in  5 each  register indices from decode
- rd1_d, rd2_d, imm_d, pc_d  in  XLEN each  register-file read data, immediate, PC
- register_write_d  in  1  instruction writes rd
- result_src_d  in  2  00 ALU, 01 load, 10 PC+4
- mem_write_d, alu_src_d, branch_d, jump_d  in  1 each  control bits
- alu_control_d  in  4  ALU operation
- pc_src_e  in  1  branch/jump in EX is taken (redirect)
- valid_ex  out  1  EX holds a real instruction
- rs1_ex, rs2_ex, rd_ex  out  5 each  registered indices (to forwarding units)
- rd1_ex, rd2_ex, imm_ex, pc_ex  out  XLEN each  registered data
- register_write_ex, mem_write_ex, alu_src_ex, branch_ex, jump_ex  out  1 each
- result_src_ex  out  2;  alu_control_ex  out  4
- stall_f, stall_d  out  1 each  hold PC and IF/ID register
- flush_d  out  1  clear IF/ID register (wrong-path)
- lw_stall_count  out  CNT_W  saturating count of load-use stall cycles

## Operation
- lw_stall = valid_d & valid_ex & (result_src_ex == 01) & (rd_ex != 0) & ((rs1_d == rd_ex) | (rs2_d == rd_ex)).
- stall_f = stall_d = lw_stall & ~pc_src_e; flush_d = pc_src_e.
- flush_e (internal) = pc_src_e | lw_stall.
- Per rising edge, priority order:
  - reset_n == 0: every register cleared to 0.
  - Else flush_e: bubble loaded. valid_ex, register_write_ex, mem_write_ex, branch_ex, jump_ex, alu_src_ex = 0; result_src_ex = 00; alu_control_ex = 0; rs1_ex/rs2_ex/rd_ex = 0 so forwarding never matches; data fields = 0.
  - Else: all *_d fields captured into *_ex; valid_ex = valid_d.
- When valid_d = 0, captured control bits are forced to 0 exactly as for a bubble; indices forced to 0.
- EX never stalls; the register captures or bubbles every cycle.
- lw_stall_count increments by 1 on each edge where stall_d == 1 and reset_n == 1. It saturates at 2^CNT_W−1 and does not wrap. Cleared only by reset.

## Timing
- Capture latency: 1 cycle, D inputs appear on *_ex outputs after the next rising edge.
- stall_f, stall_d, flush_d are combinational from current *_ex registers, valid_d/rs*_d and pc_src_e. There are no registered delays.
- Load-use: the load is in EX in cycle N with a dependent instruction in D. stall_d = 1 in N; the bubble is in EX in N+1. The dependent instruction is captured at the end of N+1 (stall deasserts since valid_ex = 0). Exactly one stall cycle per load-use.
- pc_src_e and lw_stall both high: flush wins. stall_f = stall_d = 0, flush_d = 1, bubble inserted, counter not incremented.
- Reset mid-operation overrides flush and capture on the same edge. All outputs read 0 after the edge, including stall_f/stall_d/flush_d (pc_src_e permitting) and lw_stall_count.
- rd_ex = x0 load never stalls.

## Test plan
- Reset: drive reset_n = 0 with random D inputs for one edge -> every output 0, lw_stall_count = 0.
- Pass-through: valid_d = 1, rs1_d = 3, rd_d = 7, imm_d = 0x00000010, result_src_d = 00 -> next cycle rs1_ex = 3, rd_ex = 7, imm_ex = 0x10, valid_ex = 1, no stall.
- Load-use sequence:
  - Setup: lw x5 captured (result_src_ex = 01, rd_ex = 5), then D presents rs2_d = 5.
  - stall_f = stall_d = 1 for exactly one cycle.
  - Next cycle: valid_ex = 0, rd_ex = 0.
  - Following cycle: the dependent instruction is in EX.
  - lw_stall_count = 1.
- x0 load: lw with rd_ex = 0, D rs1_d = 0 -> no stall, counter unchanged.
- Taken branch:
  - Stimulus: pc_src_e = 1 for one cycle with valid D.
  - flush_d = 1 that cycle; next cycle valid_ex = 0, register_write_ex = 0, rs1_ex = 0.
  - Simultaneous forced lw_stall condition -> stall_d = 0, counter unchanged.
- Saturation: CNT_W = 4, force 20 load-use stalls -> lw_stall_count reaches 15 and holds.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Loads a bubble on taken EX redirects and load-use hazards, and counts stall cycles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            register_write_d,
  input  logic [1:0]      result_src_d,
  input  logic            mem_write_d,
  input  logic            alu_src_d,
  input  logic            branch_d,
  input  logic            jump_d,
  input  logic [3:0]      alu_control_d,
  input  logic            pc_src_e,
  output logic            valid_ex,
  output logic [4:0]      rs1_ex,
  output logic [4:0]      rs2_ex,
  output logic [4:0]      rd_ex,
  output logic [XLEN-1:0] rd1_ex,
  output logic [XLEN-1:0] rd2_ex,
  output logic [XLEN-1:0] imm_ex,
  output logic [XLEN-1:0] pc_ex,
  output logic            register_write_ex,
  output logic            mem_write_ex,
  output logic            alu_src_ex,
  output logic            branch_ex,
  output logic            jump_ex,
  output logic [1:0]      result_src_ex,
  output logic [3:0]      alu_control_ex,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic [CNT_W-1:0] lw_stall_count
);

  logic lw_stall;
  logic flush_e;
  logic bubble;

  // A load writing a nonzero rd that the decode instruction reads must wait one cycle.
  assign lw_stall = valid_d & valid_ex & (result_src_ex == 2'b01) & (rd_ex != 5'd0) &
                    ((rs1_d == rd_ex) | (rs2_d == rd_ex));

  assign stall_f = lw_stall & ~pc_src_e;
  assign stall_d = lw_stall & ~pc_src_e;
  assign flush_d = pc_src_e;
  assign flush_e = pc_src_e | lw_stall;
  assign bubble  = flush_e | ~valid_d;

  always_ff @(posedge clk) begin
    if (!reset_n || bubble) begin
      valid_ex          <= 1'b0;
      rs1_ex            <= '0;
      rs2_ex            <= '0;
      rd_ex             <= '0;
      rd1_ex            <= '0;
      rd2_ex            <= '0;
      imm_ex            <= '0;
      pc_ex             <= '0;
      register_write_ex <= 1'b0;
      mem_write_ex      <= 1'b0;
      alu_src_ex        <= 1'b0;
      branch_ex         <= 1'b0;
      jump_ex           <= 1'b0;
      result_src_ex     <= 2'b00;
      alu_control_ex    <= 4'd0;
    end else begin
      valid_ex          <= 1'b1;
      rs1_ex            <= rs1_d;
      rs2_ex            <= rs2_d;
      rd_ex             <= rd_d;
      rd1_ex            <= rd1_d;
      rd2_ex            <= rd2_d;
      imm_ex            <= imm_d;
      pc_ex             <= pc_d;
      register_write_ex <= register_write_d;
      mem_write_ex      <= mem_write_d;
      alu_src_ex        <= alu_src_d;
      branch_ex         <= branch_d;
      jump_ex           <= jump_d;
      result_src_ex     <= result_src_d;
      alu_control_ex    <= alu_control_d;
    end
  end

  // Saturating stall counter; holds at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lw_stall_count <= '0;
    end else if (stall_d && (lw_stall_count != '1)) begin
      lw_stall_count <= lw_stall_count + CNT_W'(1);
    end
  end

endmodule
